cordic_rot_arbiter: RTL and testbench
=====================================

# cordic_rot_arbiter

Shares the single CORDIC rotation engine among N_REQ requesters (GSO, projection/normalisation units), one operation in flight at a time. Each requester owns a one-deep request slot. A round-robin scheduler issues pending slots to the engine, tracks the owner and routes the result back as a one-cycle response pulse. The block sits between the requester FSMs and the shared CORDIC instance and also drives the engine's static mode pins.

## Interface
- DATA_WIDTH, 16: x/y operand and result width
- ANGLE_WIDTH, 16: angle operand width
- N_REQ, 2: number of requesters (2..4)
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT (used only with the macro)

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_en  in  N_REQ  per-requester request strobe, one cycle
- req_xin_flat  in  DATA_WIDTH*N_REQ  x operand; requester i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- req_yin_flat  in  DATA_WIDTH*N_REQ  y operand, same packing
- req_angle_flat  in  ANGLE_WIDTH*N_REQ  angle operand, same packing
- req_busy  out  N_REQ  slot i pending or in flight
- rsp_vld  out  N_REQ  one-cycle result strobe to owner
- rsp_xout, rsp_yout  out  DATA_WIDTH each  result, shared; valid while any rsp_vld is high
- grant_id  out  2  owner of current/last operation
- err_timeout  out  1  sticky watchdog flag
- cordic_rot_en  out  1  one-cycle start to engine
- cordic_rot_xin_reg, cordic_rot_yin_reg  out  DATA_WIDTH  engine operands
- cordic_rot_angle_in_reg  out  ANGLE_WIDTH  engine angle
- cordic_rot_xout, cordic_rot_yout  in  DATA_WIDTH  engine results
- cordic_rot_opvld  in  1  engine result valid
- cordic_rot_angle_microRot_n, cordic_rot_microRot_ext_vld  out  1  tied 1
- cordic_rot_quad_in  out  2  tied 2'b00

## Operation
- Slot capture: if req_en[i] is high and req_busy[i] is low, the operands are latched and slot i is set at that edge.
  - If req_en[i] is high while req_busy[i] is high, the request is dropped and the slot contents are unchanged.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any slot is pending and not yet issued, pick the first pending index after last_grant, modulo N_REQ.
  - Load the cordic_* operand registers from that slot, set grant_id, and go to ISSUE.
- ISSUE: cordic_rot_en is high for exactly this cycle; go to WAIT.
- WAIT:
  - On cordic_rot_opvld, latch xout/yout into rsp_xout/rsp_yout and set rsp_vld[grant_id] for the next cycle.
  - At the same edge, clear slot grant_id, set last_grant to grant_id, and go to IDLE.
- cordic_rot_opvld outside WAIT is ignored, including the late result of an operation aborted by reset.
- Because the slot clears at the edge that raises rsp_vld, req_busy[i] is low in the rsp_vld[i] cycle. A req_en[i] in that cycle is accepted.
- Reset values:
  - All slots clear and last_grant = N_REQ-1, so requester 0 wins first.
  - State IDLE.
  - All outputs 0 except the tied mode pins.
- Reset mid-operation drops all pending and in-flight work. No rsp_vld is produced for it.

## Timing
- req_en at cycle 0 (engine and other slots idle): slot set at the end of cycle 0, IDLE decides in cycle 1, cordic_rot_en high in cycle 2.
- opvld in cycle n of WAIT: rsp_vld in cycle n+1, FSM in IDLE at n+1. Earliest next cordic_rot_en is n+2.
- Back-to-back issue gap is 2 cycles after opvld.
- With all N_REQ slots continuously pending, each requester is served once per N_REQ operations.
- Operands are held in the cordic_*_reg outputs from ISSUE until the next grant.

## Configuration
- CORDIC_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles pass without opvld, the arbiter pulses rsp_vld[grant_id] with rsp_xout = rsp_yout = 0, sets err_timeout (cleared only by rst), clears the slot and returns to IDLE.
  - opvld in the same cycle the counter expires wins: a normal response is produced.
- Undefined: WAIT lasts indefinitely, no counter logic, err_timeout tied 0.

## Test plan
- Single request: req_en[0] with x=16'h1000, y=0, angle=16'h2000 at cycle 0 -> cordic_rot_en in cycle 2 with those operands; opvld x=0x0B50, y=0x0B50 -> rsp_vld = 2'b01 one cycle later with rsp_xout = rsp_yout = 0x0B50.
- Simultaneous: req_en = 2'b11 after reset -> requester 0 is granted first, then 1 (grant_id 0, then 1) -> rsp_vld 01 then 10.
- Fairness: both slots re-requested every time they free -> grants alternate 0,1,0,1 over 8 operations.
- Overrun: second req_en[1] with different operands while req_busy[1] = 1 -> dropped; the engine sees only the first operands and exactly one rsp_vld[1] is produced.
- Reset in WAIT, then opvld -> no rsp_vld, req_busy = 0, no cordic_rot_en until a new req_en.
- With CORDIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no opvld -> rsp_vld[owner] 8 cycles into WAIT with 0/0 results, err_timeout = 1; the next request completes normally.

Source files
------------

// File: rtl/cordic_rot_arbiter_if.sv
// rtl/cordic_rot_arbiter_if.sv - requester-side request/response bundle of the CORDIC rotation arbiter
interface cordic_rot_arbiter_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int N_REQ       = 2
);
    logic [N_REQ-1:0]             req_en;
    logic [DATA_WIDTH*N_REQ-1:0]  req_xin_flat;
    logic [DATA_WIDTH*N_REQ-1:0]  req_yin_flat;
    logic [ANGLE_WIDTH*N_REQ-1:0] req_angle_flat;
    logic [N_REQ-1:0]             req_busy;
    logic [N_REQ-1:0]             rsp_vld;
    logic [DATA_WIDTH-1:0]        rsp_xout;
    logic [DATA_WIDTH-1:0]        rsp_yout;
    logic [1:0]                   grant_id;

    modport master (
        output req_en, req_xin_flat, req_yin_flat, req_angle_flat,
        input  req_busy, rsp_vld, rsp_xout, rsp_yout, grant_id
    );

    modport slave (
        input  req_en, req_xin_flat, req_yin_flat, req_angle_flat,
        output req_busy, rsp_vld, rsp_xout, rsp_yout, grant_id
    );
endinterface

// File: rtl/cordic_rot_arbiter.sv
// rtl/cordic_rot_arbiter.sv - round-robin sharing of one CORDIC rotation engine; CORDIC_ARB_TIMEOUT_EN adds a WAIT watchdog
module cordic_rot_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ANGLE_WIDTH    = 16,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cordic_rot_arbiter_if.slave    req_bus,
    output logic                   err_timeout,
    output logic                   cordic_rot_en,
    output logic [DATA_WIDTH-1:0]  cordic_rot_xin_reg,
    output logic [DATA_WIDTH-1:0]  cordic_rot_yin_reg,
    output logic [ANGLE_WIDTH-1:0] cordic_rot_angle_in_reg,
    input  logic [DATA_WIDTH-1:0]  cordic_rot_xout,
    input  logic [DATA_WIDTH-1:0]  cordic_rot_yout,
    input  logic                   cordic_rot_opvld,
    output logic                   cordic_rot_angle_microRot_n,
    output logic                   cordic_rot_microRot_ext_vld,
    output logic [1:0]             cordic_rot_quad_in
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;

    // Slot storage is padded to four entries so a 2-bit owner id can index it for any N_REQ.
    logic [3:0]               slot_vld;
    logic [DATA_WIDTH-1:0]    slot_x [4];
    logic [DATA_WIDTH-1:0]    slot_y [4];
    logic [ANGLE_WIDTH-1:0]   slot_a [4];
    logic [3:0]               req_en4;
    logic [4*DATA_WIDTH-1:0]  xin4;
    logic [4*DATA_WIDTH-1:0]  yin4;
    logic [4*ANGLE_WIDTH-1:0] ang4;

    logic [1:0] last_grant;
    logic [1:0] grant_id;
    logic [1:0] pick_id;
    logic       pick_found;
    logic       issue_load;
    logic       op_done;
    logic       op_expire;

    assign req_en4 = 4'(req_bus.req_en);
    assign xin4    = (4*DATA_WIDTH)'(req_bus.req_xin_flat);
    assign yin4    = (4*DATA_WIDTH)'(req_bus.req_yin_flat);
    assign ang4    = (4*ANGLE_WIDTH)'(req_bus.req_angle_flat);

    assign req_bus.req_busy = slot_vld[N_REQ-1:0];
    assign req_bus.grant_id = grant_id;

    assign cordic_rot_angle_microRot_n = 1'b1;
    assign cordic_rot_microRot_ext_vld = 1'b1;
    assign cordic_rot_quad_in          = 2'b00;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + CNT_W'(1) : '0;
            if (op_expire) err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    // Without the watchdog the flag is a constant low; the limit has no effect.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Scan from the farthest candidate back to the nearest so the first one after last_grant wins.
    always_comb begin
        logic [2:0] idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, last_grant} + 3'(k);
            if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
            if (slot_vld[idx[1:0]]) begin
                pick_found = 1'b1;
                pick_id    = idx[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cordic_rot_en = 1'b0;
        issue_load    = 1'b0;
        op_done       = 1'b0;
        op_expire     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    issue_load = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                cordic_rot_en = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (cordic_rot_opvld) begin
                    op_done   = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    op_expire = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A slot finishing and a new capture never target the same index: capture needs the slot free.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
        end else begin
            if (op_done || op_expire) slot_vld[grant_id] <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (req_en4[i] && !slot_vld[i]) slot_vld[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_en4[i] && !slot_vld[i]) begin
                slot_x[i] <= xin4[i*DATA_WIDTH +: DATA_WIDTH];
                slot_y[i] <= yin4[i*DATA_WIDTH +: DATA_WIDTH];
                slot_a[i] <= ang4[i*ANGLE_WIDTH +: ANGLE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id                <= '0;
            last_grant              <= 2'(N_REQ - 1);
            cordic_rot_xin_reg      <= '0;
            cordic_rot_yin_reg      <= '0;
            cordic_rot_angle_in_reg <= '0;
            req_bus.rsp_vld         <= '0;
            req_bus.rsp_xout        <= '0;
            req_bus.rsp_yout        <= '0;
        end else begin
            req_bus.rsp_vld <= '0;
            if (issue_load) begin
                grant_id                <= pick_id;
                cordic_rot_xin_reg      <= slot_x[pick_id];
                cordic_rot_yin_reg      <= slot_y[pick_id];
                cordic_rot_angle_in_reg <= slot_a[pick_id];
            end
            if (op_done || op_expire) begin
                req_bus.rsp_vld  <= N_REQ'(4'b0001 << grant_id);
                req_bus.rsp_xout <= op_done ? cordic_rot_xout : '0;
                req_bus.rsp_yout <= op_done ? cordic_rot_yout : '0;
                last_grant       <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// tb/tb_cordic_rot_arbiter.sv - self-checking bench for cordic_rot_arbiter with a behavioural slot/round-robin model
`timescale 1ns/1ps
module tb_cordic_rot_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int N  = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          err_timeout;
    logic          cordic_rot_en;
    logic [DW-1:0] cordic_rot_xin_reg, cordic_rot_yin_reg;
    logic [AW-1:0] cordic_rot_angle_in_reg;
    logic [DW-1:0] cordic_rot_xout, cordic_rot_yout;
    logic          cordic_rot_opvld;
    logic          cordic_rot_angle_microRot_n, cordic_rot_microRot_ext_vld;
    logic [1:0]    cordic_rot_quad_in;

    cordic_rot_arbiter_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_REQ(N)) bus ();

    cordic_rot_arbiter #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req_bus                     (bus.slave),
        .err_timeout                 (err_timeout),
        .cordic_rot_en               (cordic_rot_en),
        .cordic_rot_xin_reg          (cordic_rot_xin_reg),
        .cordic_rot_yin_reg          (cordic_rot_yin_reg),
        .cordic_rot_angle_in_reg     (cordic_rot_angle_in_reg),
        .cordic_rot_xout             (cordic_rot_xout),
        .cordic_rot_yout             (cordic_rot_yout),
        .cordic_rot_opvld            (cordic_rot_opvld),
        .cordic_rot_angle_microRot_n (cordic_rot_angle_microRot_n),
        .cordic_rot_microRot_ext_vld (cordic_rot_microRot_ext_vld),
        .cordic_rot_quad_in          (cordic_rot_quad_in)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_en       = '0;
        cordic_rot_opvld = 1'b0;
        cordic_rot_xout  = '0;
        cordic_rot_yout  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [AW-1:0] a);
        bus.req_xin_flat[i*DW +: DW]   = x;
        bus.req_yin_flat[i*DW +: DW]   = y;
        bus.req_angle_flat[i*AW +: AW] = a;
        bus.req_en[i]                  = 1'b1;
    endtask

    // Returns in the cycle where cordic_rot_en is expected (two cycles after the strobe).
    task automatic start_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [AW-1:0] a);
        set_req(i, x, y, a);
        step();
        bus.req_en = '0;
        step();
    endtask

    function automatic int rr_pick(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.req_en = '1;
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout = 16'hFFFF;
        cordic_rot_yout = 16'hFFFF;
        step();
        step();
        checks++;
        if ({cordic_rot_en, bus.rsp_vld, bus.req_busy, bus.grant_id, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: en=%b rsp_vld=%b busy=%b grant=%0d err=%b, required all 0",
                     cordic_rot_en, bus.rsp_vld, bus.req_busy, bus.grant_id, err_timeout);
        end
        checks++;
        if ({cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg, bus.rsp_xout, bus.rsp_yout} !== '0) begin
            errors++;
            $display("FAIL reset_data: x=%h y=%h a=%h rx=%h ry=%h, required all 0",
                     cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg, bus.rsp_xout, bus.rsp_yout);
        end
        checks++;
        if ({cordic_rot_angle_microRot_n, cordic_rot_microRot_ext_vld, cordic_rot_quad_in} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_tied: got %b%b%b, required 1100",
                     cordic_rot_angle_microRot_n, cordic_rot_microRot_ext_vld, cordic_rot_quad_in);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 16'h1000, 16'h0000, 16'h2000);
        step();
        bus.req_en = '0;
        checks++;
        if (bus.req_busy !== 2'b01 || cordic_rot_en !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: busy=%b en=%b, required busy=01 en=0", bus.req_busy, cordic_rot_en);
        end
        step();
        checks++;
        if ({cordic_rot_en, cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg, bus.grant_id}
            !== {1'b1, 16'h1000, 16'h0000, 16'h2000, 2'd0}) begin
            errors++;
            $display("FAIL single_issue: en=%b x=%h y=%h a=%h grant=%0d, required 1 1000 0000 2000 0",
                     cordic_rot_en, cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg, bus.grant_id);
        end
        step();
        checks++;
        if (cordic_rot_en !== 1'b0 || bus.rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL single_wait: en=%b rsp_vld=%b, required 0 00", cordic_rot_en, bus.rsp_vld);
        end
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h0B50;
        cordic_rot_yout  = 16'h0B50;
        step();
        cordic_rot_opvld = 1'b0;
        checks++;
        if ({bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, bus.req_busy} !== {2'b01, 16'h0B50, 16'h0B50, 2'b00}) begin
            errors++;
            $display("FAIL single_rsp: rsp_vld=%b x=%h y=%h busy=%b, required 01 0b50 0b50 00",
                     bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, bus.req_busy);
        end
        step();
        checks++;
        if (bus.rsp_vld !== 2'b00 || cordic_rot_xin_reg !== 16'h1000 || cordic_rot_angle_in_reg !== 16'h2000) begin
            errors++;
            $display("FAIL single_after: rsp_vld=%b x=%h a=%h, required 00 1000 2000",
                     bus.rsp_vld, cordic_rot_xin_reg, cordic_rot_angle_in_reg);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] x [N];
        logic [DW-1:0] d [N];
        for (int i = 0; i < N; i++) begin
            x[i] = DW'($urandom);
            d[i] = DW'($urandom);
        end
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, x[i], ~x[i], AW'($urandom));
        step();
        bus.req_en = '0;
        step();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cordic_rot_en !== 1'b1 || bus.grant_id !== 2'(i) || cordic_rot_xin_reg !== x[i]) begin
                errors++;
                $display("FAIL simul_issue%0d: en=%b grant=%0d x=%h, required 1 %0d %h",
                         i, cordic_rot_en, bus.grant_id, cordic_rot_xin_reg, i, x[i]);
            end
            step();
            cordic_rot_opvld = 1'b1;
            cordic_rot_xout  = d[i];
            cordic_rot_yout  = ~d[i];
            step();
            cordic_rot_opvld = 1'b0;
            checks++;
            if (bus.rsp_vld !== N'(1 << i) || bus.rsp_xout !== d[i] || bus.rsp_yout !== ~d[i]) begin
                errors++;
                $display("FAIL simul_rsp%0d: rsp_vld=%b x=%h y=%h, required %b %h %h",
                         i, bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, N'(1 << i), d[i], ~d[i]);
            end
            step();
        end
    endtask

    task automatic test_fairness();
        int got [$];
        int lat = 0;
        do_reset();
        for (int c = 0; c < 300 && got.size() < 8; c++) begin
            cordic_rot_opvld = 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    cordic_rot_opvld = 1'b1;
                    cordic_rot_xout  = DW'($urandom);
                    cordic_rot_yout  = DW'($urandom);
                end
            end
            if (cordic_rot_en === 1'b1) begin
                got.push_back(int'(bus.grant_id));
                lat = 2;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_busy[i] === 1'b0) set_req(i, DW'($urandom), DW'($urandom), AW'($urandom));
                else bus.req_en[i] = 1'b0;
            end
            step();
        end
        idle_inputs();
        checks++;
        if (got.size() < 8) begin
            errors++;
            $display("FAIL fair_count: %0d grants seen, required 8", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] != k % N) begin
                errors++;
                $display("FAIL fair_order%0d: grant %0d, required %0d", k, got[k], k % N);
            end
        end
    endtask

    task automatic test_overrun();
        int rsp_cnt = 0;
        int en_cnt = 0;
        do_reset();
        set_req(1, 16'h1111, 16'h2222, 16'h3333);
        step();
        checks++;
        if (bus.req_busy !== 2'b10) begin
            errors++;
            $display("FAIL overrun_busy: busy=%b, required 10", bus.req_busy);
        end
        set_req(1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        step();
        bus.req_en = '0;
        checks++;
        if ({cordic_rot_en, bus.grant_id, cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg}
            !== {1'b1, 2'd1, 16'h1111, 16'h2222, 16'h3333}) begin
            errors++;
            $display("FAIL overrun_issue: en=%b grant=%0d x=%h y=%h a=%h, required 1 1 1111 2222 3333",
                     cordic_rot_en, bus.grant_id, cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg);
        end
        step();
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h4444;
        step();
        cordic_rot_opvld = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.rsp_vld[1] === 1'b1) rsp_cnt++;
            if (cordic_rot_en === 1'b1) en_cnt++;
            step();
        end
        checks++;
        if (rsp_cnt != 1 || en_cnt != 0) begin
            errors++;
            $display("FAIL overrun_count: rsp=%0d en=%0d, required 1 0", rsp_cnt, en_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        int bad = 0;
        do_reset();
        start_req(0, 16'h0123, 16'h4567, 16'h89AB);
        set_req(1, 16'h7777, 16'h7777, 16'h7777);
        step();
        bus.req_en = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({cordic_rot_xin_reg, bus.req_busy, bus.grant_id} !== '0) begin
            errors++;
            $display("FAIL rstwait_clear: x=%h busy=%b grant=%0d, required 0", cordic_rot_xin_reg, bus.req_busy, bus.grant_id);
        end
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h5555;
        step();
        cordic_rot_opvld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rsp_vld !== 2'b00 || cordic_rot_en !== 1'b0 || bus.req_busy !== 2'b00) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstwait_quiet: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]  m_busy = '0, old_busy, prev_en = '0;
        logic [DW-1:0] m_x [N], m_y [N], px [N], py [N], exp_x = '0, exp_y = '0;
        logic [AW-1:0] m_a [N], pa [N];
        int m_last = N - 1, m_owner = 0, lat = 0, own;
        bit m_free = 1, free_prev = 1, rsp_due = 0, rsp_next = 0, exp_en;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            rsp_due  = rsp_next;
            old_busy = m_busy;
            if (rsp_due) m_busy[m_owner] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (prev_en[i] && !old_busy[i]) begin
                    m_busy[i] = 1'b1;
                    m_x[i] = px[i]; m_y[i] = py[i]; m_a[i] = pa[i];
                end
            end
            exp_en = free_prev && (old_busy != '0);
            checks++;
            if (cordic_rot_en !== exp_en) begin
                errors++;
                $display("FAIL rand_en t=%0d: en=%b, required %b", t, cordic_rot_en, exp_en);
            end
            if (rsp_due) begin
                checks++;
                if (bus.rsp_vld !== N'(1 << m_owner) || bus.rsp_xout !== exp_x || bus.rsp_yout !== exp_y) begin
                    errors++;
                    $display("FAIL rand_rsp t=%0d: rsp_vld=%b x=%h y=%h, required %b %h %h",
                             t, bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, N'(1 << m_owner), exp_x, exp_y);
                end
                m_last = m_owner;
                m_free = 1;
            end else begin
                checks++;
                if (bus.rsp_vld !== '0) begin
                    errors++;
                    $display("FAIL rand_norsp t=%0d: rsp_vld=%b, required 0", t, bus.rsp_vld);
                end
            end
            checks++;
            if (bus.req_busy !== m_busy) begin
                errors++;
                $display("FAIL rand_busy t=%0d: busy=%b, required %b", t, bus.req_busy, m_busy);
            end
            cordic_rot_opvld = 1'b0;
            rsp_next = 0;
            if (!m_free && lat > 0) begin
                lat--;
                if (lat == 0) begin
                    exp_x = DW'($urandom);
                    exp_y = DW'($urandom);
                    cordic_rot_opvld = 1'b1;
                    cordic_rot_xout  = exp_x;
                    cordic_rot_yout  = exp_y;
                    rsp_next = 1;
                end
            end else if (m_free && $urandom_range(0, 5) == 0) begin
                cordic_rot_opvld = 1'b1;
                cordic_rot_xout  = DW'($urandom);
                cordic_rot_yout  = DW'($urandom);
            end
            if (exp_en) begin
                own = rr_pick(old_busy, m_last);
                checks++;
                if (bus.grant_id !== 2'(own) || cordic_rot_xin_reg !== m_x[own]
                    || cordic_rot_yin_reg !== m_y[own] || cordic_rot_angle_in_reg !== m_a[own]) begin
                    errors++;
                    $display("FAIL rand_grant t=%0d: grant=%0d x=%h y=%h a=%h, required %0d %h %h %h", t, bus.grant_id,
                             cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg, own, m_x[own], m_y[own], m_a[own]);
                end
                m_owner = own;
                m_free = 0;
                lat = $urandom_range(1, 5);
            end
            free_prev = m_free;
            for (int i = 0; i < N; i++) begin
                prev_en[i] = ($urandom_range(0, 2) == 0);
                px[i] = DW'($urandom); py[i] = DW'($urandom); pa[i] = AW'($urandom);
                bus.req_xin_flat[i*DW +: DW]   = px[i];
                bus.req_yin_flat[i*DW +: DW]   = py[i];
                bus.req_angle_flat[i*AW +: AW] = pa[i];
            end
            bus.req_en = prev_en;
            step();
        end
        idle_inputs();
    endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        do_reset();
        start_req(1, 16'h0101, 16'h0202, 16'h0303);
        step();
        for (int c = 1; c < TO; c++) step();
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h1234;
        cordic_rot_yout  = 16'h5678;
        step();
        cordic_rot_opvld = 1'b0;
        checks++;
        if ({bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout} !== {2'b10, 16'h1234, 16'h5678, 1'b0}) begin
            errors++;
            $display("FAIL to_race: rsp_vld=%b x=%h y=%h err=%b, required 10 1234 5678 0",
                     bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout);
        end
        start_req(0, 16'h0A0A, 16'h0B0B, 16'h0C0C);
        step();
        for (int c = 0; c < TO; c++) begin
            if (bus.rsp_vld !== 2'b00) early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early: %0d early responses, required 0", early);
        end
        checks++;
        if ({bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout, bus.req_busy} !== {2'b01, 16'h0, 16'h0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL to_expire: rsp_vld=%b x=%h y=%h err=%b busy=%b, required 01 0 0 1 00",
                     bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout, bus.req_busy);
        end
        start_req(1, 16'h0E0E, 16'h0F0F, 16'h0D0D);
        step();
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h9999;
        cordic_rot_yout  = 16'h8888;
        step();
        cordic_rot_opvld = 1'b0;
        checks++;
        if ({bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout} !== {2'b10, 16'h9999, 16'h8888, 1'b1}) begin
            errors++;
            $display("FAIL to_next: rsp_vld=%b x=%h y=%h err=%b, required 10 9999 8888 1",
                     bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout);
        end
    endtask
`else
    task automatic test_no_timeout();
        int seen = 0;
        do_reset();
        start_req(0, 16'h0404, 16'h0505, 16'h0606);
        step();
        for (int c = 0; c < 100; c++) begin
            if (bus.rsp_vld !== 2'b00 || err_timeout !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL nto_wait: %0d cycles with rsp/err, required 0", seen);
        end
        cordic_rot_opvld = 1'b1;
        cordic_rot_xout  = 16'h7A7A;
        cordic_rot_yout  = 16'h3C3C;
        step();
        cordic_rot_opvld = 1'b0;
        checks++;
        if ({bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout} !== {2'b01, 16'h7A7A, 16'h3C3C, 1'b0}) begin
            errors++;
            $display("FAIL nto_rsp: rsp_vld=%b x=%h y=%h err=%b, required 01 7a7a 3c3c 0",
                     bus.rsp_vld, bus.rsp_xout, bus.rsp_yout, err_timeout);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bus.req_en         = '0;
        bus.req_xin_flat   = '0;
        bus.req_yin_flat   = '0;
        bus.req_angle_flat = '0;
        idle_inputs();
        step();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_reset_in_wait();
        test_random();
`ifdef CORDIC_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
